// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and types for the matrix keypad scanner.
//   KEY_CODE_W  width of a key code (row*4 + col)
//   ROWS/COLS   keypad matrix geometry
//   scan_res_t  outcome of one full scan: no key, exactly one key, or several
package keypad_pkg;

    localparam int KEY_CODE_W = 4;
    localparam int ROWS       = 4;
    localparam int COLS       = 4;

    typedef enum logic [1:0] {
        SCAN_NONE  = 2'd0,
        SCAN_ONE   = 2'd1,
        SCAN_MULTI = 2'd2
    } scan_kind_t;

    // code is only meaningful for SCAN_ONE and is kept at 0 otherwise, so
    // whole-struct equality can be used to compare scan results.
    typedef struct packed {
        scan_kind_t            kind;
        logic [KEY_CODE_W-1:0] code;
    } scan_res_t;

    localparam scan_res_t RES_NONE = '{kind: SCAN_NONE, code: '0};

endpackage

// File: rtl/key_fifo.sv
// key_fifo: small synchronous FIFO for debounced key codes.
//   clk, rst   clock and synchronous active-high reset
//   push_i     write din_i (ignored when full unless a pop happens the same cycle)
//   pop_i      drop the head entry (ignored when empty)
//   din_i      data to write
//   head_o     head entry, read combinationally (undefined when empty)
//   full_o     FIFO holds DEPTH entries
//   empty_o    FIFO holds no entries
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with whole-scan debounce and a
// key-code queue for the CPU bus glue.
//   clk          system clock
//   rst          synchronous active-high reset
//   row_o        row drive, active-low one-hot
//   col_i        raw column inputs, active-low, asynchronous
//   rd_en_i      pop the head key code
//   clr_ovf_i    clear overflow_o
//   key_code_o   head key code (row*4+col), 0 when the queue is empty
//   key_valid_o  queue non-empty
//   key_held_o   debounced state is exactly one key down
//   overflow_o   sticky: a key code was dropped because the queue was full
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ROWS-1:0]       row_o,
    input  logic [COLS-1:0]       col_i,
    input  logic                  rd_en_i,
    input  logic                  clr_ovf_i,
    output logic [KEY_CODE_W-1:0] key_code_o,
    output logic                  key_valid_o,
    output logic                  key_held_o,
    output logic                  overflow_o
);

    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);

    // Column synchronizer
    logic [COLS-1:0] col_meta_q, col_s_q;

    // Row scanning
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic             sample_en, scan_done;

    // Per-scan accumulation: low columns seen so far (saturating at 2) and
    // the code of the first one.
    logic [1:0]            acc_cnt_q, acc_cnt_d;
    logic [KEY_CODE_W-1:0] acc_code_q, acc_code_d;
    logic [2:0]            row_lows;
    logic [1:0]            row_col;
    logic [1:0]            base_cnt;
    logic [KEY_CODE_W-1:0] base_code;
    logic [2:0]            lows_sum;
    logic [1:0]            scan_cnt;
    logic [KEY_CODE_W-1:0] scan_code;
    scan_res_t             scan_res;

    // Debounce and committed state
    scan_res_t          cand_q, cand_d;
    scan_res_t          comm_q, comm_d;
    logic [STAB_W-1:0]  stab_q, stab_d;
    logic               push;

    // Queue and overflow
    logic [KEY_CODE_W-1:0] fifo_head;
    logic                  fifo_full, fifo_empty;
    logic                  ovf_set;
    logic                  overflow_q, overflow_d;

    assign sample_en = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    assign scan_done = sample_en && (row_idx_q == 2'd3);

    always_comb begin
        div_cnt_d = sample_en ? '0 : div_cnt_q + 1'b1;
        row_idx_d = sample_en ? row_idx_q + 2'd1 : row_idx_q;
    end

    // Count low columns on the currently driven row and remember which one.
    always_comb begin
        row_lows = '0;
        row_col  = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!col_s_q[c]) begin
                row_lows = row_lows + 3'd1;
                row_col  = 2'(c);
            end
        end
    end

    // Row 0 starts a fresh scan, so the accumulator from the previous scan is
    // ignored there instead of being cleared separately.
    always_comb begin
        base_cnt  = (row_idx_q == 2'd0) ? 2'd0 : acc_cnt_q;
        base_code = (row_idx_q == 2'd0) ? '0 : acc_code_q;
        lows_sum  = {1'b0, base_cnt} + row_lows;
        scan_cnt  = (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
        scan_code = (base_cnt == 2'd0 && row_lows == 3'd1) ? {row_idx_q, row_col} : base_code;
        acc_cnt_d  = sample_en ? scan_cnt : acc_cnt_q;
        acc_code_d = sample_en ? scan_code : acc_code_q;
        scan_res   = RES_NONE;
        if (scan_cnt == 2'd1) begin
            scan_res = '{kind: SCAN_ONE, code: scan_code};
        end else if (scan_cnt == 2'd2) begin
            scan_res = '{kind: SCAN_MULTI, code: '0};
        end
    end

    // Debounce: scan_res is complete in the row-3 sample cycle, so the
    // candidate, the committed state and the push all resolve in that cycle.
    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        comm_d = comm_q;
        if (scan_done) begin
            if (scan_res == cand_q) begin
                if (stab_q != STAB_MAX) begin
                    stab_d = stab_q + 1'b1;
                end
            end else begin
                cand_d = scan_res;
                stab_d = STAB_W'(1);
            end
            // MULTI never commits; the previous committed state holds.
            if (stab_d == STAB_MAX && cand_d.kind != SCAN_MULTI) begin
                comm_d = cand_d;
            end
        end
        push = scan_done && (comm_d.kind == SCAN_ONE) && (comm_d != comm_q);
    end

    // When full, a pop (rd_en_i) makes room in the same cycle.
    assign ovf_set    = push & fifo_full & ~rd_en_i;
    assign overflow_d = ovf_set | (overflow_q & ~clr_ovf_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta_q <= '1;
            col_s_q    <= '1;
            div_cnt_q  <= '0;
            row_idx_q  <= '0;
            acc_cnt_q  <= '0;
            acc_code_q <= '0;
            cand_q     <= RES_NONE;
            stab_q     <= '0;
            comm_q     <= RES_NONE;
            overflow_q <= 1'b0;
        end else begin
            col_meta_q <= col_i;
            col_s_q    <= col_meta_q;
            div_cnt_q  <= div_cnt_d;
            row_idx_q  <= row_idx_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
            cand_q     <= cand_d;
            stab_q     <= stab_d;
            comm_q     <= comm_d;
            overflow_q <= overflow_d;
        end
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_CODE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (rd_en_i),
        .din_i   (comm_d.code),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign row_o       = ~(ROWS'(1) << row_idx_q);
    assign key_code_o  = fifo_empty ? '0 : fifo_head;
    assign key_valid_o = ~fifo_empty;
    assign key_held_o  = (comm_q.kind == SCAN_ONE);
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with a scan-level reference
// model (set of pressed keys -> scan result, last-N-results debounce, queue).
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 4;
    localparam int DEPTH    = 4;
    localparam int SCAN_LEN = 4 * SCAN_DIV;
    localparam int R_NONE   = -1;
    localparam int R_MULTI  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_o;
    logic [3:0] col_i;
    logic       rd_en_i = 1'b0;
    logic       clr_ovf_i = 1'b0;
    logic [3:0] key_code_o;
    logic       key_valid_o, key_held_o, overflow_o;

    logic [15:0] pressed = '0;
    logic [3:0]  one4 = 4'b0001;
    logic [3:0]  exp_row;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_o       (row_o),
        .col_i       (col_i),
        .rd_en_i     (rd_en_i),
        .clr_ovf_i   (clr_ovf_i),
        .key_code_o  (key_code_o),
        .key_valid_o (key_valid_o),
        .key_held_o  (key_held_o),
        .overflow_o  (overflow_o)
    );

    // Keypad: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_i = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (pressed[k] && !row_o[k / 4]) col_i[k % 4] = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  m_cyc = 0;
    int  m_hist[$];
    int  m_comm = R_NONE;
    int  m_q[$];
    bit  m_ovf = 1'b0;
    bit  m_live = 1'b0;
    int  m_res;
    bit  m_push, m_set, m_same;

    function automatic int scan_result(input logic [15:0] p);
        int n = 0;
        int idx = 0;
        for (int k = 0; k < 16; k++) begin
            if (p[k]) begin
                n++;
                idx = k;
            end
        end
        if (n == 0) return R_NONE;
        if (n == 1) return idx;
        return R_MULTI;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_cyc = 0;
            m_hist.delete();
            m_comm = R_NONE;
            m_q.delete();
            m_ovf = 1'b0;
            m_live = 1'b1;
        end else begin
            m_push = 1'b0;
            m_set  = 1'b0;
            if (m_cyc % SCAN_LEN == SCAN_LEN - 1) begin
                m_res = scan_result(pressed);
                m_hist.push_back(m_res);
                if (m_hist.size() > DEB) void'(m_hist.pop_front());
                m_same = (m_hist.size() == DEB);
                foreach (m_hist[i]) if (m_hist[i] != m_res) m_same = 1'b0;
                if (m_same && m_res != R_MULTI) begin
                    if (m_res != R_NONE && m_res != m_comm) m_push = 1'b1;
                    m_comm = m_res;
                end
            end
            if (rd_en_i && m_q.size() > 0) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_res);
                else m_set = 1'b1;
            end
            if (m_set) m_ovf = 1'b1;
            else if (clr_ovf_i) m_ovf = 1'b0;
            m_cyc++;
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            exp_row = ~(one4 << ((m_cyc / SCAN_DIV) % 4));
            chk("row_o", row_o, exp_row);
            chk("key_valid_o", key_valid_o, m_q.size() > 0);
            chk("key_code_o", key_code_o, (m_q.size() > 0) ? m_q[0] : 0);
            chk("key_held_o", key_held_o, m_comm != R_NONE);
            chk("overflow_o", overflow_o, m_ovf);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [15:0] key(input int k);
        logic [15:0] b = 16'd1;
        return b << k;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align();
        while (m_cyc % SCAN_LEN != 0) @(negedge clk);
    endtask

    task automatic hold(input logic [15:0] keys, input int scans);
        align();
        pressed = keys;
        wait_cycles(scans * SCAN_LEN);
    endtask

    task automatic pop(input int exp_code, input string name);
        chk(name, key_code_o, exp_code);
        rd_en_i = 1'b1;
        @(negedge clk);
        rd_en_i = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_ovf_i = 1'b1;
        @(negedge clk);
        clr_ovf_i = 1'b0;
    endtask

    initial begin
        wait_cycles(3);
        rst = 1'b0;

        // 1: reset values and row rotation
        chk("t1_row0", row_o, 4'b1110);
        chk("t1_valid", key_valid_o, 0);
        chk("t1_code", key_code_o, 0);
        chk("t1_ovf", overflow_o, 0);
        chk("t1_held", key_held_o, 0);
        wait_cycles(4);  chk("t1_row1", row_o, 4'b1101);
        wait_cycles(4);  chk("t1_row2", row_o, 4'b1011);
        wait_cycles(4);  chk("t1_row3", row_o, 4'b0111);
        wait_cycles(4);  chk("t1_row0b", row_o, 4'b1110);

        // 2: key 9 held for 20 scans; exact latency of the first push
        align();
        pressed = key(9);
        wait_cycles(4 * SCAN_LEN - 1);
        chk("t2_valid_before", key_valid_o, 0);
        wait_cycles(1);
        chk("t2_valid_after", key_valid_o, 1);
        chk("t2_code", key_code_o, 9);
        chk("t2_held", key_held_o, 1);
        wait_cycles(16 * SCAN_LEN);
        pop(9, "t2_pop");
        chk("t2_single", key_valid_o, 0);
        hold('0, 5);
        chk("t2_released", key_held_o, 0);

        // 3: bounce never commits
        hold(key(9), 2);
        hold('0, 1);
        hold(key(9), 2);
        hold('0, 5);
        chk("t3_held", key_held_o, 0);
        chk("t3_valid", key_valid_o, 0);

        // 4: two keys together never commit; single key afterwards does
        hold(key(4) | key(7), 6);
        chk("t4_multi_valid", key_valid_o, 0);
        chk("t4_multi_held", key_held_o, 0);
        hold(key(4), 4);
        chk("t4_valid", key_valid_o, 1);
        chk("t4_code", key_code_o, 4);
        pop(4, "t4_pop");
        chk("t4_single", key_valid_o, 0);
        hold('0, 4);

        // 5: overflow, clear, and set-wins-over-clear
        hold(key(1), 4); hold('0, 4);
        hold(key(2), 4); hold('0, 4);
        hold(key(3), 4); hold('0, 4);
        hold(key(5), 4); hold('0, 4);
        hold(key(6), 4); hold('0, 4);
        chk("t5_ovf", overflow_o, 1);
        chk("t5_head", key_code_o, 1);
        pulse_clr();
        chk("t5_ovf_clr", overflow_o, 0);
        align();
        pressed = key(6);
        wait_cycles(4 * SCAN_LEN - 1);
        clr_ovf_i = 1'b1;
        wait_cycles(1);
        clr_ovf_i = 1'b0;
        chk("t5_set_wins", overflow_o, 1);
        pressed = '0;
        pop(1, "t5_pop1");
        pop(2, "t5_pop2");
        pop(3, "t5_pop3");
        pop(5, "t5_pop5");
        chk("t5_empty", key_valid_o, 0);
        pulse_clr();
        chk("t5_ovf_clr2", overflow_o, 0);
        hold('0, 4);

        // 6: reset mid-debounce with a queued key and a held key
        hold(key(2), 4);
        chk("t6_pre_valid", key_valid_o, 1);
        hold(key(9), 2);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        chk("t6_row", row_o, 4'b1110);
        chk("t6_valid", key_valid_o, 0);
        chk("t6_code", key_code_o, 0);
        chk("t6_held", key_held_o, 0);
        chk("t6_ovf", overflow_o, 0);
        wait_cycles(4 * SCAN_LEN - 1);
        chk("t6_valid_before", key_valid_o, 0);
        wait_cycles(1);
        chk("t6_valid_after", key_valid_o, 1);
        chk("t6_code9", key_code_o, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
